apsk_llr_sched: RTL

Sequencer and LLR formatter for the exhaustive-demapper comparison unit. It admits symbols into the min-compare pipeline and stalls that pipeline under output backpressure through its enable. It tracks per-slot valid and mode tags, forms max-log LLRs from the 12 per-bit minimum metrics, and serializes 4, 5 or 6 LLRs per symbol (16/32/64-APSK) to the decoder interface.

---
 rtl/apsk_demap_pkg.sv | 33 +++
 rtl/apsk_llr_sched_if.sv | 35 +++
 rtl/cu_tag_pipe.sv | 36 +++
 rtl/apsk_llr_sched.sv | 93 +++++++++
 4 files changed

// File: rtl/apsk_demap_pkg.sv
// Shared definitions for the APSK exhaustive-demapper back end.
// Holds the default widths and latency, the constellation mode encoding,
// the bits-per-symbol lookup and the LLR sign convention.
package apsk_demap_pkg;
  localparam int WL_DEF      = 18;  // metric width
  localparam int LLR_WL_DEF  = 19;  // LLR width, signed
  localparam int BIT_NUM_DEF = 6;   // max bits per symbol
  localparam int MC_LAT_DEF  = 5;   // comparison-unit depth in enabled cycles

  // 1: LLR = min1 - min0, so a positive LLR favours bit=0.
  localparam bit LLR_POS_IS_BIT0 = 1'b1;

  typedef enum logic [1:0] {
    MODE_16  = 2'd0,
    MODE_32  = 2'd1,
    MODE_64  = 2'd2,
    MODE_RSV = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Reserved mode is serialized like 64APSK.
  function automatic logic [2:0] nbits(input mode_t m);
    case (m)
      MODE_16: return 3'd4;
      MODE_32: return 3'd5;
      default: return 3'd6;
    endcase
  endfunction
endpackage

// File: rtl/apsk_llr_sched_if.sv
// Symbol-in / LLR-out bundle of apsk_llr_sched.
//   in_valid/in_mode/in_ready : symbol admission handshake
//   cu_en                     : comparison-unit enable
//   min0_bus/min1_bus         : per-bit minimum metrics from the comparison unit
//   llr_valid/ready/data/idx/last : serialized LLR stream to the decoder
//   busy                      : symbols still in flight
// master = the surroundings (upstream, comparison unit, decoder); slave = the scheduler.
interface apsk_llr_sched_if import apsk_demap_pkg::*; #(
  parameter int WL     = WL_DEF,
  parameter int LLR_WL = LLR_WL_DEF,
  parameter int NB     = BIT_NUM_DEF
);
  logic              in_valid;
  logic [1:0]        in_mode;
  logic              in_ready;
  logic              cu_en;
  logic [NB*WL-1:0]  min0_bus;
  logic [NB*WL-1:0]  min1_bus;
  logic              llr_valid;
  logic              llr_ready;
  logic [LLR_WL-1:0] llr_data;
  logic [2:0]        llr_idx;
  logic              llr_last;
  logic              busy;

  modport master (
    output in_valid, in_mode, min0_bus, min1_bus, llr_ready,
    input  in_ready, cu_en, llr_valid, llr_data, llr_idx, llr_last, busy
  );

  modport slave (
    input  in_valid, in_mode, min0_bus, min1_bus, llr_ready,
    output in_ready, cu_en, llr_valid, llr_data, llr_idx, llr_last, busy
  );
endinterface

// File: rtl/cu_tag_pipe.sv
// Valid/mode tags that travel alongside the comparison-unit pipeline.
// Shifts only on `shift` (the same enable given to the comparison unit), so the
// tail tag always lines up with the metrics on min0_bus/min1_bus.
//   clk, rst_n          : clock, synchronous active-low reset (clears valids)
//   shift               : advance the pipe
//   in_vld, in_mode     : tag loaded into stage 0
//   tail_vld, tail_mode : last stage
//   any_vld             : OR of all stage valids
module cu_tag_pipe import apsk_demap_pkg::*; #(
  parameter int MC_LAT = MC_LAT_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  shift,
  input  logic  in_vld,
  input  mode_t in_mode,
  output logic  tail_vld,
  output mode_t tail_mode,
  output logic  any_vld
);
  logic [MC_LAT-1:0]      vld_pipe;
  logic [MC_LAT-1:0][1:0] mode_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (shift) begin
      vld_pipe  <= {vld_pipe[MC_LAT-2:0], in_vld};
      mode_pipe <= {mode_pipe[MC_LAT-2:0], in_mode};
    end
  end

  assign tail_vld  = vld_pipe[MC_LAT-1];
  assign tail_mode = mode_t'(mode_pipe[MC_LAT-1]);
  assign any_vld   = |vld_pipe;
endmodule

// File: rtl/apsk_llr_sched.sv
// Sequencer and LLR formatter for the exhaustive-demapper comparison unit.
// Admits symbols into the min-compare pipeline, freezes it under output
// backpressure via cu_en, forms LLR[b] = min1[b] - min0[b] and serializes
// 4/5/6 LLRs per symbol according to the symbol's mode.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : apsk_llr_sched_if.slave (admission, metrics, LLR stream, busy)
module apsk_llr_sched import apsk_demap_pkg::*; #(
  parameter int wordlength     = WL_DEF,
  parameter int LLR_wordlength = LLR_WL_DEF,
  parameter int bit_num        = BIT_NUM_DEF,
  parameter int MC_LAT         = MC_LAT_DEF
) (
  input logic             clk,
  input logic             rst_n,
  apsk_llr_sched_if.slave bus
);
  state_t state, state_nxt;
  logic   tail_vld, any_vld;
  mode_t  tail_mode, buf_mode;
  logic [2:0] idx;
  logic [bit_num-1:0][LLR_wordlength-1:0] llr_buf, llr_new;
  logic buf_full, last, hs, advance, capture;

  // The buffer holds exactly one symbol; it is full whenever the FSM emits.
  assign buf_full = (state == EMIT);
  assign last     = (idx == nbits(buf_mode) - 3'd1);
  assign hs       = buf_full & bus.llr_ready;
  // The pipe may move only if the buffer is free now or frees on this edge.
  assign advance  = rst_n & (!buf_full | (hs & last));
  assign capture  = advance & tail_vld;

  cu_tag_pipe #(.MC_LAT(MC_LAT)) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift     (advance),
    .in_vld    (bus.in_valid),
    .in_mode   (mode_t'(bus.in_mode)),
    .tail_vld  (tail_vld),
    .tail_mode (tail_mode),
    .any_vld   (any_vld)
  );

  // Zero-extended operands: one extra bit makes the difference exact.
  for (genvar b = 0; b < bit_num; b++) begin : g_llr
    logic [LLR_wordlength-1:0] m0, m1;
    assign m0 = LLR_wordlength'(bus.min0_bus[b*wordlength +: wordlength]);
    assign m1 = LLR_wordlength'(bus.min1_bus[b*wordlength +: wordlength]);
    assign llr_new[b] = LLR_POS_IS_BIT0 ? (m1 - m0) : (m0 - m1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = EMIT;
      EMIT: if (hs && last) state_nxt = capture ? EMIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = advance;
    bus.cu_en     = advance;
    bus.llr_valid = 1'b0;
    bus.llr_data  = '0;
    bus.llr_idx   = '0;
    bus.llr_last  = 1'b0;
    bus.busy      = rst_n & (any_vld | buf_full);
    if (rst_n && state == EMIT) begin
      bus.llr_valid = 1'b1;
      bus.llr_data  = llr_buf[idx];
      bus.llr_idx   = idx;
      bus.llr_last  = last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      buf_mode <= MODE_16;
    end else begin
      if (hs) idx <= last ? 3'd0 : idx + 3'd1;
      if (capture) begin
        llr_buf  <= llr_new;
        buf_mode <= tail_mode;
      end
    end
  end
endmodule
